// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sum = a + b + c_in, one CHUNK-bit ripple slice per clock, carry held between slices.
// Define SCA_OVERFLOW_EN to add a registered two's-complement overflow output.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SCA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             cy_q, cy_d, carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic [CHUNK-1:0] ch_a, ch_b, ch_s;
  logic             chain_c;
`ifdef SCA_OVERFLOW_EN
  logic             ch_cm;
  logic             ovf_q, ovf_d;
`endif

  // One CHUNK-bit ripple chain of full adders on the current slice.
  always_comb begin
    ch_a    = a_q[cnt_q*CHUNK +: CHUNK];
    ch_b    = b_q[cnt_q*CHUNK +: CHUNK];
    ch_s    = '0;
    chain_c = cy_q;
`ifdef SCA_OVERFLOW_EN
    ch_cm   = cy_q;
`endif
    for (int i = 0; i < CHUNK; i++) begin
`ifdef SCA_OVERFLOW_EN
      ch_cm   = chain_c;
`endif
      ch_s[i] = ch_a[i] ^ ch_b[i] ^ chain_c;
      chain_c = (ch_a[i] & ch_b[i]) | (chain_c & (ch_a[i] ^ ch_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SCA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cy_d    = c_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[cnt_q*CHUNK +: CHUNK] = ch_s;
        cy_d = chain_c;
        if (cnt_q == LAST) begin
          // Outputs change only here, so partial sums are never visible.
          sum_d   = res_d;
          carry_d = chain_c;
`ifdef SCA_OVERFLOW_EN
          ovf_d   = ch_cm ^ chain_c;
`endif
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef SCA_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule
